// File: rtl/seg7_scan_reader_if.sv
// Frame output channel of seg7_scan_reader: assembled hex digits, per-digit
// glyph error flags, valid/ready handshake and the sticky overrun flag.
interface seg7_scan_reader_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] out_data;
    logic [NDIG-1:0]   out_err;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;

    modport master (
        output out_data,
        output out_err,
        output out_valid,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_err,
        input  out_valid,
        input  overrun,
        output out_ready
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Samples a multiplexed 7-segment display, qualifies each digit glyph for
// stability, decodes it back to hex and assembles complete frames.
module seg7_scan_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      seg,
    input  logic [NDIG-1:0] dig_en,
    seg7_scan_reader_if.master out_if
);
    // Counter saturates one above STABLE so a long dwell never re-accepts.
    localparam int CW = $clog2(STABLE + 2);

    logic [NDIG-1:0]   r_prev_dig;
    logic [6:0]        r_prev_seg;
    logic [CW-1:0]     r_cnt;
    logic [4*NDIG-1:0] r_slot_data;
    logic [NDIG-1:0]   r_slot_err;
    logic [NDIG-1:0]   r_mask;
    logic [4*NDIG-1:0] r_out_data;
    logic [NDIG-1:0]   r_out_err;
    logic              r_out_valid;
    logic              r_overrun;

    logic              w_onehot;
    logic              w_same;
    logic [CW-1:0]     w_run;
    logic              w_accept;
    logic [4:0]        w_dec;
    logic [4*NDIG-1:0] w_data_nxt;
    logic [NDIG-1:0]   w_err_nxt;
    logic [NDIG-1:0]   w_mask_nxt;
    logic              w_complete;

    // Returns {err, value}; anything but an exact glyph decodes to 0 with err.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'b1111110: f_decode = 5'h00;
            7'b0110000: f_decode = 5'h01;
            7'b1101101: f_decode = 5'h02;
            7'b1111001: f_decode = 5'h03;
            7'b0110011: f_decode = 5'h04;
            7'b1011011: f_decode = 5'h05;
            7'b1011111: f_decode = 5'h06;
            7'b1110000: f_decode = 5'h07;
            7'b1111111: f_decode = 5'h08;
            7'b1111011: f_decode = 5'h09;
            7'b1110111: f_decode = 5'h0A;
            7'b0011111: f_decode = 5'h0B;
            7'b1001110: f_decode = 5'h0C;
            7'b0111101: f_decode = 5'h0D;
            7'b1001111: f_decode = 5'h0E;
            7'b1000111: f_decode = 5'h0F;
            default:    f_decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        w_onehot = (dig_en != '0) && ((dig_en & (dig_en - NDIG'(1))) == '0);
        w_same   = w_onehot && (dig_en == r_prev_dig) && (seg == r_prev_seg);
        // w_run is the dwell length including the current cycle.
        if (!w_onehot)
            w_run = '0;
        else if (!w_same)
            w_run = CW'(1);
        else if (r_cnt > CW'(STABLE))
            w_run = r_cnt;
        else
            w_run = r_cnt + CW'(1);
        w_accept = w_onehot && (w_run == CW'(STABLE));
        w_dec    = f_decode(seg);

        w_data_nxt = r_slot_data;
        w_err_nxt  = r_slot_err;
        w_mask_nxt = r_mask;
        if (w_accept) begin
            for (int i = 0; i < NDIG; i++) begin
                if (dig_en[i]) begin
                    w_data_nxt[4*i +: 4] = w_dec[3:0];
                    w_err_nxt[i]         = w_dec[4];
                end
            end
            w_mask_nxt = r_mask | dig_en;
        end
        w_complete = w_accept && (&w_mask_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_dig  <= '0;
            r_prev_seg  <= '0;
            r_cnt       <= '0;
            r_slot_data <= '0;
            r_slot_err  <= '0;
            r_mask      <= '0;
            r_out_data  <= '0;
            r_out_err   <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_prev_dig  <= dig_en;
            r_prev_seg  <= seg;
            r_cnt       <= w_run;
            r_slot_data <= w_data_nxt;
            r_slot_err  <= w_err_nxt;
            r_mask      <= w_complete ? '0 : w_mask_nxt;
            if (w_complete) begin
                r_out_data  <= w_data_nxt;
                r_out_err   <= w_err_nxt;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_if.out_ready)
                    r_overrun <= 1'b1;
            end else if (r_out_valid && out_if.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_if.out_data  = r_out_data;
    assign out_if.out_err   = r_out_err;
    assign out_if.out_valid = r_out_valid;
    assign out_if.overrun   = r_overrun;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NDIG=4, STABLE=3).
module tb_seg7_scan_reader;
    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      seg;
    logic [NDIG-1:0] dig_en;
    logic [6:0]      G [16];
    int              errors = 0;
    int              checks = 0;

    seg7_scan_reader_if #(.NDIG(NDIG)) u_if ();

    seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .seg    (seg),
        .dig_en (dig_en),
        .out_if (u_if)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input int d, input logic [6:0] s, input int n);
        dig_en    = '0;
        dig_en[d] = 1'b1;
        seg       = s;
        repeat (n) cyc();
    endtask

    task automatic consume();
        dig_en = '0;
        u_if.out_ready = 1'b1;
        cyc();
        u_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        checks++; if (u_if.out_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", u_if.out_data); end
        checks++; if (u_if.out_err !== 4'h0) begin errors++; $display("FAIL reset_err got=%b exp=0", u_if.out_err); end
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", u_if.out_valid); end
        checks++; if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", u_if.overrun); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        scan(0, G[3], 4);
        scan(1, G[4], 4);
        scan(2, G[12], 4);
        scan(3, G[15], 2);
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", u_if.out_valid); end
        cyc();
        checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", u_if.out_valid); end
        checks++; if (u_if.out_data !== 16'hFC43) begin errors++; $display("FAIL basic_data got=%h exp=fc43", u_if.out_data); end
        checks++; if (u_if.out_err !== 4'h0) begin errors++; $display("FAIL basic_err got=%b exp=0000", u_if.out_err); end
        cyc();
        checks++; if (u_if.out_data !== 16'hFC43) begin errors++; $display("FAIL basic_hold got=%h exp=fc43", u_if.out_data); end
        consume();
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume got=%b exp=0", u_if.out_valid); end
    endtask

    task automatic test_illegal();
        scan(0, G[0], 3);
        scan(1, 7'b0000001, 3);
        scan(2, G[2], 3);
        scan(3, G[3], 3);
        checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL illegal_valid got=%b exp=1", u_if.out_valid); end
        checks++; if (u_if.out_data !== 16'h3200) begin errors++; $display("FAIL illegal_data got=%h exp=3200", u_if.out_data); end
        checks++; if (u_if.out_err !== 4'b0010) begin errors++; $display("FAIL illegal_err got=%b exp=0010", u_if.out_err); end
        consume();
    endtask

    task automatic test_glitch();
        scan(0, G[1], 3);
        scan(1, G[5], 3);
        scan(3, G[7], 3);
        scan(2, G[9], 2);
        scan(2, G[8], 1);
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL glitch_short got=%b exp=0", u_if.out_valid); end
        scan(2, G[9], 2);
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL glitch_rearm got=%b exp=0", u_if.out_valid); end
        cyc();
        checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL glitch_valid got=%b exp=1", u_if.out_valid); end
        checks++; if (u_if.out_data !== 16'h7951) begin errors++; $display("FAIL glitch_data got=%h exp=7951", u_if.out_data); end
        consume();
    endtask

    task automatic test_multihot();
        scan(0, G[10], 3);
        scan(1, G[11], 3);
        scan(2, G[12], 3);
        dig_en = 4'b0011;
        seg    = G[8];
        repeat (10) cyc();
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL multihot_valid got=%b exp=0", u_if.out_valid); end
        scan(3, G[14], 3);
        checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL multihot_done got=%b exp=1", u_if.out_valid); end
        checks++; if (u_if.out_data !== 16'hECBA) begin errors++; $display("FAIL multihot_data got=%h exp=ecba", u_if.out_data); end
        consume();
    endtask

    task automatic test_overrun();
        for (int d = 0; d < 4; d++) scan(d, G[1], 3);
        checks++; if (u_if.out_data !== 16'h1111) begin errors++; $display("FAIL ovr_first_data got=%h exp=1111", u_if.out_data); end
        checks++; if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag got=%b exp=0", u_if.overrun); end
        for (int d = 0; d < 4; d++) scan(d, G[d+2], 3);
        checks++; if (u_if.out_data !== 16'h5432) begin errors++; $display("FAIL ovr_second_data got=%h exp=5432", u_if.out_data); end
        checks++; if (u_if.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", u_if.overrun); end
        checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", u_if.out_valid); end
        consume();
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume got=%b exp=0", u_if.out_valid); end
        checks++; if (u_if.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", u_if.overrun); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        dig_en = '0;
        cyc();
        rst = 1'b0;
        for (int d = 0; d < 4; d++) scan(d, G[d+6], 3);
        checks++; if (u_if.out_data !== 16'h9876) begin errors++; $display("FAIL b2b_first got=%h exp=9876", u_if.out_data); end
        scan(0, G[13], 3);
        scan(1, G[14], 3);
        scan(2, G[15], 3);
        scan(3, G[0], 2);
        u_if.out_ready = 1'b1;
        cyc();
        u_if.out_ready = 1'b0;
        checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", u_if.out_valid); end
        checks++; if (u_if.out_data !== 16'h0FED) begin errors++; $display("FAIL b2b_data got=%h exp=0fed", u_if.out_data); end
        checks++; if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", u_if.overrun); end
    endtask

    task automatic test_reset_midframe();
        scan(0, G[7], 3);
        scan(1, G[7], 3);
        dig_en = 4'b0100;
        seg    = G[2];
        rst    = 1'b1;
        cyc();
        checks++; if (u_if.out_valid !== 1'b0 || u_if.out_data !== 16'h0) begin errors++; $display("FAIL rst_during got=%b/%h exp=0/0", u_if.out_valid, u_if.out_data); end
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (u_if.out_valid !== 1'b0 || u_if.out_data !== 16'h0 || u_if.out_err !== 4'h0 || u_if.overrun !== 1'b0) begin
            errors++; $display("FAIL rst_after got=%b/%h/%b/%b exp=0/0/0/0", u_if.out_valid, u_if.out_data, u_if.out_err, u_if.overrun); end
        repeat (2) cyc();
        scan(3, G[3], 3);
        checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_partial got=%b exp=0", u_if.out_valid); end
        scan(0, G[4], 3);
        scan(1, G[5], 3);
        checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL rst_frame_valid got=%b exp=1", u_if.out_valid); end
        checks++; if (u_if.out_data !== 16'h3254) begin errors++; $display("FAIL rst_frame_data got=%h exp=3254", u_if.out_data); end
    endtask

    initial begin
        G[0]  = 7'b1111110; G[1]  = 7'b0110000; G[2]  = 7'b1101101; G[3]  = 7'b1111001;
        G[4]  = 7'b0110011; G[5]  = 7'b1011011; G[6]  = 7'b1011111; G[7]  = 7'b1110000;
        G[8]  = 7'b1111111; G[9]  = 7'b1111011; G[10] = 7'b1110111; G[11] = 7'b0011111;
        G[12] = 7'b1001110; G[13] = 7'b0111101; G[14] = 7'b1001111; G[15] = 7'b1000111;
        rst = 1'b1;
        seg = '0;
        dig_en = '0;
        u_if.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_illegal();
        test_glitch();
        test_multihot();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart of the team's hex-to-7-segment decoder: samples the segment lines and one-hot digit strobes of a multiplexed NDIG-digit display, qualifies each digit pattern for stability, maps it back to its 4-bit hex value, and assembles complete frames. It sits between a display-scan monitor (or an external segment bus) and downstream logic. It presents each assembled multi-digit value on a valid/ready handshake.

## Interface
- NDIG, 4, number of multiplexed digits (2..8)
- STABLE, 3, consecutive cycles a (strobe, segment) pair must hold before acceptance (1..15)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- seg  in  7  segment lines, bit 6 = a … bit 0 = g, active-high
- dig_en  in  NDIG  digit strobes; bit i selects digit i (digit 0 = least significant nibble)
- out_data  out  4*NDIG  assembled frame, digit i in bits [4i+3:4i]
- out_err  out  NDIG  per-digit flag: the accepted pattern was not a legal hex glyph
- out_valid  out  1  out_data/out_err hold a frame not yet consumed
- out_ready  in  1  consumer accepts the frame when high together with out_valid
- overrun  out  1  sticky: a completed frame replaced an unconsumed one

## Operation
- Glyph map (seg → value), exact match only: 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9, 1110111→A, 0011111→B, 1001110→C, 0111101→D, 1001111→E, 1000111→F. Any other pattern → value 0, err bit 1.
- Stability counter: it counts consecutive cycles in which dig_en is exactly one-hot and the (dig_en, seg) pair equals the previous cycle's pair. Any change, an all-zero dig_en, or a multi-hot dig_en clears the count and re-arms acceptance.
- Acceptance: this happens exactly once per dwell, in the cycle in which the pair has been present STABLE consecutive cycles. Acceptance writes the value and err bit into digit slot i and sets capture-mask bit i. A longer dwell causes no further acceptance. A re-visited digit before frame completion overwrites its slot; the mask bit stays set.
- Frame completion: this occurs on the acceptance that makes the capture mask all-ones. All slots (including the one just accepted) load into out_data/out_err, out_valid is set, and the mask clears. Slot contents are kept, but only freshly accepted digits count toward the next frame.
- Handshake: a frame is consumed at an edge with out_valid and out_ready both high. out_valid then falls, unless a new frame completes on the same edge, in which case out_valid stays 1 with the new data. out_data/out_err remain stable while out_valid is high and no new frame completes.
- Overrun: a frame that completes while out_valid=1 and out_ready=0 replaces out_data/out_err and sets overrun. Overrun is cleared only by rst.

## Timing
- All outputs are registered. Reset values: out_data=0, out_err=0, out_valid=0, overrun=0. Internal capture mask, slots, stability counter, and previous-sample register are all 0.
- A pair first sampled at the edge ending cycle t is accepted at the edge ending cycle t+STABLE-1. The slot, and a completed frame, are visible from cycle t+STABLE.
- STABLE=1: every cycle with a one-hot strobe that differs from the previous cycle's pair is an acceptance.
- rst mid-frame: the partial frame is discarded. A pending unconsumed frame is dropped (out_valid=0). The first pair sampled after rst is treated as new.
- No combinational path exists from out_ready to any output.

## Test plan
- Reset, then scan digits 0..3 with glyphs 1111001, 0110011, 1001110, 1000111, 4 cycles each, STABLE=3 → out_data=16'hFC43, out_err=0, out_valid=1 exactly 3 cycles after digit 3's first cycle.
- Digit 1 strobed with 0000001 (illegal), others legal, then complete the frame → out_data nibble 1 = 0, out_err=4'b0010.
- Glitch: digit 2's pattern changes after 2 of 3 cycles, then returns → no acceptance until 3 fresh stable cycles. Multi-hot dig_en=0011 for 10 cycles → no acceptance.
- Hold out_ready=0 across two full frames → second frame's data appears, overrun=1, out_valid stays 1. Then pulse out_ready for 1 cycle → out_valid=0 next cycle, overrun remains 1.
- Frame completes on the same edge as out_valid&&out_ready → out_valid stays 1 with new data, overrun=0.
- Assert rst after 2 of 4 digits are accepted, then scan all 4 digits → the frame contains only post-reset values. All outputs read 0 during and immediately after rst.
